// File: rtl/card_pick_judge.sv
// Card button conditioning, tile fetch/compare and chicken position tracking.
// Feeds key/go/win to the game control FSM and advances on its adv command.
module card_pick_judge #(
    parameter int N_CARDS   = 12,
    parameter int N_TILES   = 24,
    parameter int N_ANIMALS = 4,
    parameter int AW        = 2,
    parameter int PW        = 5,
    parameter int GOAL_POS  = 23,
    parameter int DB_CYCLES = 16
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic [N_CARDS-1:0] btn,
    input  logic               adv,
    output logic [PW-1:0]      tile_addr,
    input  logic [AW-1:0]      tile_data,
    output logic               key,
    output logic               go,
    output logic               win,
    output logic [PW-1:0]      pos
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);
    localparam logic [PW-1:0] LAST = PW'(N_TILES - 1);
    localparam logic [PW-1:0] GOAL = PW'(GOAL_POS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CMP   = 2'd2
    } state_t;

    state_t state, state_n;

    logic [N_CARDS-1:0] sync1, sync2;
    logic [N_CARDS-1:0] db, db_q, ev;
    logic [CW-1:0]      cnt [N_CARDS];

    logic          adv_q, adv_rise;
    logic          hit;
    logic [AW-1:0] pick_a, pick_r, pick_n;
    logic [PW-1:0] pos_n, addr_n;
    logic          go_n, win_n, match;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync1 <= '0;
            sync2 <= '0;
            db_q  <= '0;
            adv_q <= 1'b0;
            for (int i = 0; i < N_CARDS; i++) cnt[i] <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            db_q  <= db;
            adv_q <= adv;
            for (int i = 0; i < N_CARDS; i++) begin
                if (!sync2[i])
                    cnt[i] <= '0;
                else if (cnt[i] != DB_MAX)
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CARDS; i++) db[i] = (cnt[i] == DB_MAX);
    end

    assign ev       = db & ~db_q;
    assign adv_rise = adv & ~adv_q;

    // Scan high to low so the lowest pressed index ends up selected.
    always_comb begin
        hit    = 1'b0;
        pick_a = '0;
        for (int i = N_CARDS - 1; i >= 0; i--) begin
            if (ev[i]) begin
                hit    = 1'b1;
                pick_a = AW'(i % N_ANIMALS);
            end
        end
    end

    assign match = (tile_data == pick_r);

    always_comb begin
        state_n = state;
        pos_n   = pos;
        addr_n  = tile_addr;
        pick_n  = pick_r;
        go_n    = go;
        win_n   = win;
        unique case (state)
            IDLE: begin
                if (adv_rise && go) begin
                    pos_n = nxt(pos);
                    go_n  = 1'b0;
                    win_n = 1'b0;
                end
                // A same-cycle advance has already moved pos_n.
                if (hit) begin
                    pick_n  = pick_a;
                    addr_n  = nxt(pos_n);
                    state_n = FETCH;
                end
            end
            FETCH: begin
                go_n    = match;
                win_n   = match && (tile_addr == GOAL);
                state_n = CMP;
            end
            CMP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            pos       <= '0;
            tile_addr <= '0;
            pick_r    <= '0;
            go        <= 1'b0;
            win       <= 1'b0;
        end else begin
            state     <= state_n;
            pos       <= pos_n;
            tile_addr <= addr_n;
            pick_r    <= pick_n;
            go        <= go_n;
            win       <= win_n;
        end
    end

    assign key = (state == CMP);

endmodule
